tri_bus_arbiter: RTL and testbench
==================================

// Module: tri_bus_arbiter
// PURPOSE
//  - Round-robin arbiter/sequencer for a shared multi-driver (tri/triand) 16-bit bus.
//  - Grants one requester at a time and drives the per-requester output enables.
//  - Registers the owner's word onto bus_q.
//  - Inserts guaranteed idle turnaround cycles between owners so no two drivers ever overlap.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  DATA_W    16   bus width (shortint-sized word)
//  TURN_CYC  1    idle cycles between owners (0..7); 0 = back-to-back handover
//  MAX_HOLD  64   max consecutive grant cycles per owner (used only with timeout feature)
// PORTS
//  clk        in   1                clock, all state on rising edge
//  rst_n      in   1                asynchronous, active-low reset
//  req_i      in   NUM_REQ          bus request, level; held high while bus wanted
//  data_i     in   NUM_REQ*DATA_W   per-requester write word, [k] valid while gnt_o[k]
//  gnt_o      out  NUM_REQ          one-hot grant, registered
//  oe_o       out  NUM_REQ          driver enable, identical to gnt_o (separate net for tri drivers)
//  owner_o    out  $clog2(NUM_REQ)  index of current/last owner
//  busy_o     out  1                high in GRANT and TURNAROUND
//  bus_q      out  DATA_W           registered bus word
//  timeout_o  out  1                1-cycle pulse on forced release (0 when feature off)
// BEHAVIOUR
//  - Reset (async assert, sync deassert expected upstream):
//    - state=IDLE; gnt_o=oe_o=0; owner_o=NUM_REQ-1 (req 0 wins first); busy_o=0; bus_q=0; timeout_o=0; counters=0.
//  - IDLE, |req_i at cycle t:
//    - pick first set req after owner_o (wrapping modulo NUM_REQ).
//    - gnt_o/oe_o one-hot and owner_o updated at t+1; state=GRANT. Request-to-grant latency is 1 cycle.
//  - GRANT:
//    - bus_q <= data_i[owner] every cycle (1-cycle latency data_i -> bus_q).
//    - while req_i[owner]=1, grant holds.
//    - req_i[owner]=0 sampled at t: gnt_o=0 and bus_q=0 at t+1.
//    - next state: TURNAROUND if TURN_CYC>0, else IDLE.
//  - TURNAROUND:
//    - gnt_o=0, bus_q=0, busy_o=1 for exactly TURN_CYC cycles (down-counter); then IDLE.
//    - minimum owner-to-owner gap = TURN_CYC + 1 cycles of gnt_o=0.
//    - with TURN_CYC=0, gap = 1 cycle (the IDLE arbitration cycle).
//  - Changes of non-owner req_i during GRANT/TURNAROUND are ignored until the next IDLE.
//  - The owner re-requesting immediately after release receives lowest priority (strict round-robin).
//  - req_i=0 in IDLE: state stays IDLE, outputs hold their reset-equivalent idle values.
//  - gnt_o is never multi-hot; oe_o==gnt_o every cycle.
//  - rst_n low mid-GRANT: gnt_o/oe_o clear immediately (asynchronously); bus_q=0.
//  - States: IDLE(2'd0) GRANT(2'd1) TURNAROUND(2'd2); 2'd3 unreachable, recovers to IDLE.
// CONFIGURATION
//  - Macro TRI_BUS_ARB_TIMEOUT_EN defined:
//    - a hold counter counts GRANT cycles.
//    - in the MAX_HOLD-th grant cycle, the grant is revoked at the next edge regardless of req_i.
//    - timeout_o pulses 1 in that revocation cycle; the state then proceeds as a normal release.
//    - owner_o is unchanged, so round-robin skips that owner next.
//  - Macro undefined: no hold counter; timeout_o tied to 0; grant held indefinitely.
// STRUCTURE
//  - Package tri_bus_arb_pkg:
//    - arb_state_e enum (IDLE/GRANT/TURNAROUND)
//    - DATA_W default constant
//    - owner index typedef helper
//  - Sub-module rr_pick (combinational):
//    - inputs req vector and last owner; outputs one-hot pick + index + valid.
//    - instantiated once.
//  - FSM, counters and bus_q register live in tri_bus_arbiter.
// TESTING
//  - Reset with req_i=4'b1111: gnt_o=0 during reset.
//    - first grant 4'b0001 one cycle after release.
//    - owner order 0,1,2,3,0 with TURN_CYC+1 idle cycles between grants.
//  - Single requester req_i=4'b0100, data_i[2]=16'hA5A5:
//    - gnt_o=4'b0100 at t+1, bus_q=16'hA5A5 at t+2.
//    - drop req: gnt_o=0, bus_q=0 next cycle.
//  - TURN_CYC=3: measure gap between two owners = 4 cycles with gnt_o=0 and busy_o=1 for the 3 turnaround cycles.
//  - Owner 1 drops and re-raises req in the same cycle that req 3 rises: next grant goes to 3, then 1.
//  - Reset asserted mid-GRANT: gnt_o/oe_o/bus_q go to 0 asynchronously.
//    - after release, arbitration restarts at req 0.
//  - TRI_BUS_ARB_TIMEOUT_EN, MAX_HOLD=8, req_i[0] held high:
//    - grant lasts exactly 8 cycles; timeout_o pulses once.
//    - pending req 1 is granted next.
//    - without the macro, grant persists for 100 cycles and timeout_o stays 0.

Source files
------------

// File: rtl/tri_bus_arb_pkg.sv
// Shared types and constants for the round-robin tri-bus arbiter.
// Optional hold timeout is enabled by defining TRI_BUS_ARB_TIMEOUT_EN.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int OWNER_W_MAX = 3;

  // Widest owner index (8 requesters).
  typedef logic [OWNER_W_MAX-1:0] owner_max_t;

  function automatic int owner_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after the last owner,
// wrapping modulo N.
module rr_pick
  import tri_bus_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = owner_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] last,
  output logic [N-1:0]  pick_oh,
  output logic [OW-1:0] pick_idx,
  output logic          valid
);

  logic [OW-1:0] cand;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = OW'((int'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid         = 1'b1;
        pick_idx      = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin sequencer for a shared tri-state bus with idle turnaround.
// Define TRI_BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 64,
  localparam int OW      = owner_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        oe_o,
  output logic [OW-1:0]             owner_o,
  output logic                      busy_o,
  output logic [DATA_W-1:0]         bus_q,
  output logic                      timeout_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TURN_CYC < 0 ||
      TURN_CYC > 7 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("tri_bus_arbiter: parameter out of range");
  end

  localparam logic [2:0] TURN_LOAD =
    (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;

  arb_state_e          state, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [OW-1:0]       owner_d;
  logic [DATA_W-1:0]   bus_d;
  logic [2:0]          turn_cnt, turn_d;
  logic                rel;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [OW-1:0]       pick_idx;
  logic                pick_valid;
  logic [DATA_W-1:0]   words [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_word
    assign words[k] = data_i[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .OW (OW)
  ) u_pick (
    .req      (req_i),
    .last     (owner_o),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

`ifdef TRI_BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_cnt, hold_d;
  logic          timeout_d;
`endif

  always_comb begin
    state_d = state;
    gnt_d   = gnt_o;
    owner_d = owner_o;
    bus_d   = bus_q;
    turn_d  = turn_cnt;
    rel     = 1'b0;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
    hold_d    = hold_cnt;
    timeout_d = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        bus_d = '0;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        hold_d = '0;
`endif
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        rel = !req_i[owner_o];
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        hold_d = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          rel       = 1'b1;
          timeout_d = req_i[owner_o];
        end
`endif
        if (rel) begin
          gnt_d   = '0;
          bus_d   = '0;
          turn_d  = TURN_LOAD;
          state_d = (TURN_CYC > 0) ? TURNAROUND : IDLE;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
        end else begin
          bus_d = words[owner_o];
        end
      end
      TURNAROUND: begin
        gnt_d = '0;
        bus_d = '0;
        if (turn_cnt == 3'd0) state_d = IDLE;
        else turn_d = turn_cnt - 3'd1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        bus_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_o    <= '0;
      owner_o  <= OW'(NUM_REQ - 1);
      bus_q    <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt_o    <= gnt_d;
      owner_o  <= owner_d;
      bus_q    <= bus_d;
      turn_cnt <= turn_d;
    end
  end

`ifdef TRI_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      hold_cnt  <= hold_d;
      timeout_o <= timeout_d;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  assign oe_o   = gnt_o;
  assign busy_o = (state == GRANT) || (state == TURNAROUND);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed scoreboard bench for tri_bus_arbiter (TURN_CYC=1 and TURN_CYC=3).
// Timeout expectations follow TRI_BUS_ARB_TIMEOUT_EN.
module tb_tri_bus_arbiter;
  localparam int N = 4;
  localparam int W = 16;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
  localparam int EXP_HOLD  = 8;
  localparam int EXP_PULSE = 1;
  localparam logic [N-1:0] EXP_NXT = 4'b0010;
`else
  localparam int EXP_HOLD  = 100;
  localparam int EXP_PULSE = 0;
  localparam logic [N-1:0] EXP_NXT = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_a, req_b, gnt_a, oe_a, gnt_b, oe_b;
  logic [N*W-1:0] data_a, data_b;
  logic [1:0] owner_a, owner_b;
  logic busy_a, busy_b, to_a, to_b;
  logic [W-1:0] bus_a, bus_b;

  int cmps = 0;
  int errs = 0;
  logic [N-1:0] exp_gnt_q[$];
  logic [W-1:0] exp_bus_q[$];

  always #5 clk = ~clk;

  tri_bus_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .TURN_CYC(1), .MAX_HOLD(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .data_i(data_a),
    .gnt_o(gnt_a), .oe_o(oe_a), .owner_o(owner_a),
    .busy_o(busy_a), .bus_q(bus_a), .timeout_o(to_a)
  );

  tri_bus_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .TURN_CYC(3), .MAX_HOLD(8)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .data_i(data_b),
    .gnt_o(gnt_b), .oe_o(oe_b), .owner_o(owner_b),
    .busy_o(busy_b), .bus_q(bus_b), .timeout_o(to_b)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int idle);
    idle = 0;
    while (gnt_a == '0 && idle < 30) begin
      idle++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle, held, pulses, zeros;
    logic [N-1:0] e, nxt;
    logic [3:0] busy_pat;

    req_a = '1;
    req_b = '0;
    data_a = '0;
    data_b = '0;
    for (int k = 0; k < N; k++) begin
      data_a[k*W +: W] = W'(32'h1000 + k);
      data_b[k*W +: W] = W'(32'h2000 + k);
    end
    step();
    step();
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_oe", 32'(oe_a), 32'h0);
    chk("rst_owner", 32'(owner_a), 32'h3);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_bus", 32'(bus_a), 32'h0);
    chk("rst_timeout", 32'(to_a), 32'h0);

    exp_gnt_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b0010);
    exp_gnt_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(idle);
      e = exp_gnt_q.pop_front();
      chk("order_gnt", 32'(gnt_a), 32'(e));
      chk("order_oe", 32'(oe_a), 32'(e));
      chk("order_gap", 32'(idle), (g == 0) ? 32'd1 : 32'd2);
      req_a = req_a & ~e;
      step();
      req_a = req_a | e;
    end
    req_a = '0;
    repeat (3) step();

    // Single requester with bus data latency.
    data_a[2*W +: W] = 16'hA5A5;
    exp_bus_q.push_back(16'hA5A5);
    req_a = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt_a), 32'h4);
    chk("single_bus_early", 32'(bus_a), 32'h0);
    step();
    chk("single_bus", 32'(bus_a), 32'(exp_bus_q.pop_front()));
    data_a[2*W +: W] = 16'h5A5A;
    exp_bus_q.push_back(16'h5A5A);
    step();
    chk("single_bus2", 32'(bus_a), 32'(exp_bus_q.pop_front()));
    req_a = '0;
    step();
    chk("drop_gnt", 32'(gnt_a), 32'h0);
    chk("drop_bus", 32'(bus_a), 32'h0);
    chk("drop_busy", 32'(busy_a), 32'h1);
    step();
    chk("idle_busy", 32'(busy_a), 32'h0);
    chk("idle_owner", 32'(owner_a), 32'h2);

    // Owner 1 drops while 3 rises, then re-requests.
    req_a = 4'b0010;
    wait_gnt(idle);
    chk("rr_own1", 32'(gnt_a), 32'h2);
    req_a = 4'b1000;
    step();
    req_a = 4'b1010;
    wait_gnt(idle);
    chk("rr_3_first", 32'(gnt_a), 32'h8);
    req_a = 4'b0010;
    step();
    wait_gnt(idle);
    chk("rr_1_second", 32'(gnt_a), 32'h2);
    req_a = '0;
    repeat (3) step();

    // Asynchronous reset in the middle of a grant.
    req_a = 4'b0001;
    wait_gnt(idle);
    step();
    chk("pre_rst_bus", 32'(bus_a), 32'h1000);
    req_a = 4'b1001;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt_a), 32'h0);
    chk("arst_oe", 32'(oe_a), 32'h0);
    chk("arst_bus", 32'(bus_a), 32'h0);
    chk("arst_owner", 32'(owner_a), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart_req0", 32'(gnt_a), 32'h1);
    req_a = '0;
    repeat (3) step();

    // Long hold with a second requester pending.
    req_a = 4'b0001;
    wait_gnt(idle);
    chk("hold_start", 32'(gnt_a), 32'h1);
    req_a = 4'b0011;
    held = 0;
    pulses = 0;
    nxt = '0;
    for (int i = 0; i < 100; i++) begin
      if (to_a && i < 12) pulses++;
      if (held == i && gnt_a == 4'b0001) held++;
      else if (nxt == '0 && gnt_a != '0) nxt = gnt_a;
      step();
    end
    chk("hold_len", 32'(held), 32'(EXP_HOLD));
    chk("hold_pulses", 32'(pulses), 32'(EXP_PULSE));
    chk("hold_next", 32'(nxt), 32'(EXP_NXT));
    req_a = '0;
    repeat (3) step();

    // Turnaround of three cycles.
    req_b = 4'b0001;
    zeros = 0;
    while (gnt_b == '0 && zeros < 30) begin
      zeros++;
      step();
    end
    chk("t3_first", 32'(gnt_b), 32'h1);
    req_b = 4'b0010;
    step();
    zeros = 0;
    busy_pat = '0;
    while (gnt_b == '0 && zeros < 30) begin
      if (zeros < 4) busy_pat = {busy_b, busy_pat[3:1]};
      zeros++;
      step();
    end
    chk("t3_gap", 32'(zeros), 32'd4);
    chk("t3_busy", 32'(busy_pat), 32'h7);
    chk("t3_gnt", 32'(gnt_b), 32'h2);
    chk("t3_oe", 32'(oe_b), 32'h2);
    chk("t3_owner", 32'(owner_b), 32'h1);
    chk("t3_bus", 32'(bus_b), 32'h0);
    chk("t3_timeout", 32'(to_b), 32'h0);
    req_b = '0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
